// File: rtl/surf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// surf_wb_arbiter
//
// Two-master, one-slave WISHBONE arbiter for the SURF 22-bit register space.
// m0 is the serial (boardman) master, m1 is the TURF-command master. Whole bus
// cycles are granted (cyc framing) with round-robin fairness on ties. Single
// clock domain (regclk).
//
// Handshake: a master owns the bus from the clock after its cyc is seen in
// IDLE until it drops cyc. Within that tenure each access is offered with
// stb=1 and completes in the cycle where ack=1. stb/adr/dat/we are held
// stable until that ack. An ack is only meaningful while the same master
// holds stb=1.
//
// Optional feature: define SURF_WB_ARB_TIMEOUT_EN to build the stall watchdog.
// It forces an ack carrying TIMEOUT_DATA once an access has been stalled for
// TIMEOUT_CYCLES clocks. Without the macro, timeout_o is tied low and a
// stalled slave holds the grant indefinitely.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i         master N bus-cycle request, strobe, write enable
//   mN_adr_i/dat_i              master N address / write data
//   mN_ack_o/dat_o              acknowledge / read data back to master N
//   s_cyc_o/stb_o/we_o          slave-side control from the granted master
//   s_adr_o/dat_o               slave-side address / write data
//   s_ack_i/dat_i               slave acknowledge / read data
//   timeout_o                   one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module surf_wb_arbiter #(
    parameter int unsigned              ADDR_WIDTH     = 22,
    parameter int unsigned              DATA_WIDTH     = 32,
    parameter int unsigned              TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0]    TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic                    m0_ack_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic                    m1_ack_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic                    s_ack_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,

    output logic                    timeout_o
);

    // Configuration sanity: the watchdog compare needs at least two states.
    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("surf_wb_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    // Master that most recently received a grant; the other one wins a tie.
    logic   last_q, last_d;
    logic   gnt0, gnt1;
    logic   timeout_fire;

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_q) begin
                        state_d = ST_GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_GNT1;
                        last_d  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            // Releasing always passes through IDLE, so a waiting master is
            // re-arbitrated there rather than handed the bus directly.
            ST_GNT0: if (!m0_cyc_i) state_d = ST_IDLE;
            ST_GNT1: if (!m1_cyc_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);

    // ------------------------------------------------------------------
    // Slave-side mux: combinational from the granted master, zero in IDLE
    // ------------------------------------------------------------------
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------
`ifdef SURF_WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wdog_cnt_q;

    // Counts clocks of the current unacknowledged strobe. A real ack in the
    // terminal cycle wins, so the fire term requires s_ack_i low.
    assign timeout_fire = s_stb_o && !s_ack_i &&
                          (wdog_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wdog_cnt_q <= '0;
        end else if (!s_stb_o || s_ack_i || timeout_fire) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Return path. Acks in IDLE (stray) and to the waiting master are
    // dropped by the grant qualifier.
    // ------------------------------------------------------------------
    assign m0_ack_o  = gnt0 && ((s_ack_i && m0_stb_i) || timeout_fire);
    assign m1_ack_o  = gnt1 && ((s_ack_i && m1_stb_i) || timeout_fire);
    assign m0_dat_o  = (gnt0 && timeout_fire) ? TIMEOUT_DATA : s_dat_i;
    assign m1_dat_o  = (gnt1 && timeout_fire) ? TIMEOUT_DATA : s_dat_i;
    assign timeout_o = timeout_fire;

endmodule

// File: tb/tb_surf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_surf_wb_arbiter
//
// Bench for surf_wb_arbiter. A reference model tracks who owns the bus (as an
// integer owner index plus the last-served master) and derives every slave-side
// and return-path value from the arbitration rules; a compare process checks
// the DUT against it each falling edge. Directed scenarios pin the model with
// literal expectations, then randomized masters and a randomized slave run.
// Build with SURF_WB_ARB_TIMEOUT_EN defined to exercise the watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_surf_wb_arbiter;

    localparam int          AW = 22;
    localparam int          DW = 32;
    localparam int          TC = 16;
    localparam logic [31:0] TD = 32'hDEADBEEF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic [1:0]    mcyc = '0;
    logic [1:0]    mstb = '0;
    logic [1:0]    mwe  = '0;
    logic [AW-1:0] madr [2];
    logic [DW-1:0] mdat [2];
    logic          s_ack    = 1'b0;
    logic [DW-1:0] s_dat_in = '0;

    wire           m0_ack, m1_ack;
    wire [DW-1:0]  m0_dat, m1_dat;
    wire           s_cyc, s_stb, s_we, timeout;
    wire [AW-1:0]  s_adr;
    wire [DW-1:0]  s_dat_out;

    surf_wb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TC),
        .TIMEOUT_DATA   (TD)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m0_cyc_i   (mcyc[0]),
        .m0_stb_i   (mstb[0]),
        .m0_we_i    (mwe[0]),
        .m0_adr_i   (madr[0]),
        .m0_dat_i   (mdat[0]),
        .m0_ack_o   (m0_ack),
        .m0_dat_o   (m0_dat),
        .m1_cyc_i   (mcyc[1]),
        .m1_stb_i   (mstb[1]),
        .m1_we_i    (mwe[1]),
        .m1_adr_i   (madr[1]),
        .m1_dat_i   (mdat[1]),
        .m1_ack_o   (m1_ack),
        .m1_dat_o   (m1_dat),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_dat_out),
        .s_ack_i    (s_ack),
        .s_dat_i    (s_dat_in),
        .timeout_o  (timeout)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 = nobody, else index of the master holding the bus.
    int owner = -1;
    bit last  = 1'b1;
    int stall = 0;   // consecutive clocks the owner's strobe went unanswered

    function automatic bit wd_fire();
`ifdef SURF_WB_ARB_TIMEOUT_EN
        return (owner >= 0) && mstb[owner] && !s_ack && (stall == TC - 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1;
            last  = 1'b1;
            stall = 0;
        end else begin
            bit f;
            bit strobe;
            strobe = (owner >= 0) && mstb[owner];
            f      = wd_fire();
            stall  = (strobe && !s_ack && !f) ? stall + 1 : 0;
            if (owner < 0) begin
                if (mcyc == 2'b11)  owner = last ? 0 : 1;
                else if (mcyc[0])   owner = 0;
                else if (mcyc[1])   owner = 1;
                if (owner >= 0)     last = (owner == 1);
            end else if (!mcyc[owner]) begin
                owner = -1;
            end
        end
    end

    // One compare per falling edge against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            logic          e_cyc, e_stb, e_we;
            logic [AW-1:0] e_adr;
            logic [DW-1:0] e_dat;
            logic [1:0]    e_ack;
            bit            f;
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
            if (owner >= 0) begin
                e_cyc = mcyc[owner];
                e_stb = mstb[owner];
                e_we  = mwe[owner];
                e_adr = madr[owner];
                e_dat = mdat[owner];
            end
            f = wd_fire();
            e_ack[0] = (owner == 0) && ((s_ack && mstb[0]) || f);
            e_ack[1] = (owner == 1) && ((s_ack && mstb[1]) || f);
            chk("s_cyc", s_cyc, e_cyc);
            chk("s_stb", s_stb, e_stb);
            chk("s_we", s_we, e_we);
            chk("s_adr", s_adr, e_adr);
            chk("s_dat", s_dat_out, e_dat);
            chk("m0_ack", m0_ack, e_ack[0]);
            chk("m1_ack", m1_ack, e_ack[1]);
            chk("timeout", timeout, f);
            if (e_ack[0]) chk("m0_dat", m0_dat, f ? TD : s_dat_in);
            if (e_ack[1]) chk("m1_dat", m1_dat, f ? TD : s_dat_in);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  rem    [2] = '{0, 0};
    int  wait_n [2] = '{0, 0};
    bit  got    [2] = '{0, 0};
    bit  start_en   = 1'b1;
    int  sl_wait    = 0;
    int  sl_lat     = 0;

    task automatic new_access(input int n);
        mstb[n]   = 1'b1;
        mwe[n]    = 1'($urandom_range(0, 1));
        madr[n]   = AW'($urandom_range(0, 32'h3F_FFFF));
        mdat[n]   = $urandom();
        wait_n[n] = 0;
    endtask

    task automatic master_step(input int n);
        if (!mcyc[n]) begin
            if (start_en && $urandom_range(0, 3) == 0) begin
                mcyc[n] = 1'b1;
                rem[n]  = $urandom_range(1, 3);
                new_access(n);
            end
        end else if (got[n]) begin
            rem[n]--;
            if (rem[n] == 0) begin
                mcyc[n] = 1'b0;
                mstb[n] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                new_access(n);
            end else begin
                mstb[n] = 1'b0;
            end
        end else if (!mstb[n]) begin
            new_access(n);
        end else begin
            wait_n[n]++;
            if (wait_n[n] > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL master%0d_wait: got no ack after %0d cycles, expected one", n, wait_n[n]);
                mcyc[n] = 1'b0;
                mstb[n] = 1'b0;
            end
        end
    endtask

    task automatic slave_step();
        s_dat_in = $urandom();
        if (s_cyc && s_stb) begin
            if (sl_wait >= sl_lat) begin
                s_ack   = 1'b1;
                sl_wait = 0;
                sl_lat  = $urandom_range(0, 3);
            end else begin
                s_ack = 1'b0;
                sl_wait++;
            end
        end else begin
            s_ack   = ($urandom_range(0, 7) == 0);
            sl_wait = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        madr = '{default: '0};
        mdat = '{default: '0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_timeout", timeout, 0);
        chk_on = 1'b1;
        rst_n  = 1'b1;

        // Single read by m0, slave acks one cycle after stb.
        tick(); mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 22'h000004;
        #1 chk("lat_idle_cyc", s_cyc, 0);
        tick(); #1 chk("lat_gnt_cyc", s_cyc, 1);
        chk("rd_adr", s_adr, 22'h000004);
        chk("rd_ack_wait", m0_ack, 0);
        tick(); s_ack = 1; s_dat_in = 32'h12340001;
        #1 chk("rd_ack", m0_ack, 1);
        chk("rd_dat", m0_dat, 32'h12340001);
        chk("rd_m1_ack", m1_ack, 0);
        tick(); s_ack = 0; mcyc[0] = 0; mstb[0] = 0;
        #1 chk("rd_ack_once", m0_ack, 0);
        chk("release_cyc", s_cyc, 0);
        tick();

        // Stray acks in IDLE, idle bus and with a pending request.
        s_ack = 1;
        #1 chk("stray_m0", m0_ack, 0);
        chk("stray_m1", m1_ack, 0);
        tick(); mcyc[0] = 1; mstb[0] = 1; s_ack = 1;
        #1 chk("stray_pend_m0", m0_ack, 0);
        tick(); s_ack = 0; mcyc[0] = 0; mstb[0] = 0;
        tick();

        // m1 requests during a 3-access m0 burst.
        tick(); mcyc[0] = 1; mstb[0] = 1; madr[0] = 22'h000010;
        tick(); mcyc[1] = 1; mstb[1] = 1; mwe[1] = 1;
        madr[1] = 22'h000100; mdat[1] = 32'hA5A5A5A5;
        s_ack = 1; s_dat_in = 32'h1;
        #1 chk("burst_ack0", m0_ack, 1);
        chk("burst_m1_blocked", m1_ack, 0);
        chk("burst_adr0", s_adr, 22'h000010);
        for (int k = 1; k < 3; k++) begin
            tick(); madr[0] = AW'(32'h10 + 4 * k); s_ack = 1;
            #1 chk("burst_ack", m0_ack, 1);
            chk("burst_adr", s_adr, AW'(32'h10 + 4 * k));
        end
        tick(); mcyc[0] = 0; mstb[0] = 0; s_ack = 0;
        #1 chk("burst_release", s_cyc, 0);
        chk("burst_m1_wait", m1_ack, 0);
        tick(); #1 chk("handover_idle", s_cyc, 0);
        tick(); s_ack = 1;
        #1 chk("handover_cyc", s_cyc, 1);
        chk("m1_wr_adr", s_adr, 22'h000100);
        chk("m1_wr_dat", s_dat_out, 32'hA5A5A5A5);
        chk("m1_wr_we", s_we, 1);
        chk("m1_wr_ack", m1_ack, 1);
        chk("m1_wr_m0_ack", m0_ack, 0);
        tick(); s_ack = 0; mcyc[1] = 0; mstb[1] = 0; mwe[1] = 0;
        tick();

        // Reset asserted while m0 holds the bus with an ack in flight.
        tick(); mcyc[0] = 1; mstb[0] = 1; madr[0] = 22'h000008;
        tick(); #1 chk("pre_rst_cyc", s_cyc, 1);
        s_ack = 1;
        #1 rst_n = 0;
        #1 chk("rst_async_cyc", s_cyc, 0);
        chk("rst_async_stb", s_stb, 0);
        chk("rst_async_ack", m0_ack, 0);
        mcyc[0] = 0; mstb[0] = 0; s_ack = 0;
        tick(); tick(); rst_n = 1;
        tick();

        // Ties: m0 first after reset, then m1 wins the next tie.
        mcyc = 2'b11; mstb = 2'b11; mwe = 2'b00;
        madr[0] = 22'h000020; madr[1] = 22'h000030;
        #1 chk("tie_idle_cyc", s_cyc, 0);
        tick(); #1 chk("tie1_adr", s_adr, 22'h000020);
        s_ack = 1;
        #1 chk("tie1_m0_ack", m0_ack, 1);
        chk("tie1_m1_ack", m1_ack, 0);
        tick(); s_ack = 0; mcyc[0] = 0; mstb[0] = 0;
        #1 chk("tie1_release", s_cyc, 0);
        tick(); mcyc[0] = 1; mstb[0] = 1; madr[0] = 22'h000024;
        #1 chk("tie_gap_cyc", s_cyc, 0);
        tick(); #1 chk("tie2_adr", s_adr, 22'h000030);
        chk("tie2_cyc", s_cyc, 1);
        s_ack = 1;
        #1 chk("tie2_m1_ack", m1_ack, 1);
        chk("tie2_m0_ack", m0_ack, 0);
        tick(); s_ack = 0; mcyc[1] = 0; mstb[1] = 0;
        #1 chk("tie2_release", s_cyc, 0);
        tick(); #1 chk("tie3_gap", s_cyc, 0);
        tick(); #1 chk("tie3_adr", s_adr, 22'h000024);
        s_ack = 1;
        #1 chk("tie3_m0_ack", m0_ack, 1);
        tick(); s_ack = 0; mcyc[0] = 0; mstb[0] = 0;
        tick();

        // Slave never acks.
        tick(); mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 22'h000040;
        tick();
`ifdef SURF_WB_ARB_TIMEOUT_EN
        for (int i = 0; i < TC; i++) begin
            #1 chk("wd_ack", m0_ack, (i == TC - 1));
            chk("wd_pulse", timeout, (i == TC - 1));
            if (i == TC - 1) chk("wd_dat", m0_dat, TD);
            tick();
        end
`else
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 1000; i++) begin
                #1 if (m0_ack || timeout) seen++;
                tick();
            end
            chk("wd_off_no_ack", seen, 0);
            chk("wd_off_hold", s_cyc, 1);
        end
`endif
        mcyc[0] = 0; mstb[0] = 0;
        tick(); tick();

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            tick();
            master_step(0);
            master_step(1);
            #1 slave_step();
            #1 got[0] = m0_ack;
            got[1] = m1_ack;
        end
        start_en = 1'b0;
        for (int c = 0; c < 300 && mcyc != 2'b00; c++) begin
            tick();
            master_step(0);
            master_step(1);
            #1 slave_step();
            #1 got[0] = m0_ack;
            got[1] = m1_ack;
        end
        chk("drain_idle", mcyc, 0);
        tick(); s_ack = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
